// File: rtl/weight_rom_stream_arbiter.sv
// ============================================================================
//  Module      : weight_rom_stream_arbiter
//  Description : Round-robin arbiter that streams one full weight-ROM pass per
//                grant through a credit-controlled output FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_rom_stream_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 576,
   parameter int ADDR_WIDTH = $clog2(DEPTH) + 1,
   parameter int FIFO_DEPTH = 4,
   localparam int c_id_width = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_grant,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_q,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic [c_id_width-1:0] out_id,
   output logic                  busy
);

   localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   state_t                  r_state;
   logic [NUM_REQ-1:0]      r_grant;
   logic [ADDR_WIDTH-1:0]   r_cnt;
   logic [ADDR_WIDTH-1:0]   r_addr_hold;
   logic [1:0]              r_vld;
   logic [1:0]              r_lst;
   logic [c_id_width-1:0]   r_rr_ptr;
   logic [c_id_width-1:0]   r_id;

   logic [DATA_WIDTH:0]     r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]      r_wr_ptr;
   logic [c_ptr_w-1:0]      r_rd_ptr;
   logic [c_cnt_w-1:0]      r_count;

   logic [2*NUM_REQ-1:0]    w_rot;
   logic                    w_found;
   int                      w_sum;
   int                      w_nxt;
   logic [c_id_width-1:0]   w_win;
   logic [c_id_width-1:0]   w_nxt_ptr;
   logic [c_cnt_w:0]        w_used;
   logic                    w_issue;
   logic                    w_push;
   logic                    w_pop;
   logic [DATA_WIDTH:0]     w_head;

   // Rotating the doubled request vector puts the round-robin start at bit 0.
   assign w_rot = {req_valid, req_valid} >> r_rr_ptr;

   always_comb begin
      w_found = 1'b0;
      w_sum   = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_found = 1'b1;
            w_sum   = int'(r_rr_ptr) + i;
         end
      end
      if (w_sum >= NUM_REQ) begin
         w_sum = w_sum - NUM_REQ;
      end
      w_nxt = (w_sum + 1 >= NUM_REQ) ? 0 : w_sum + 1;
      w_win     = c_id_width'(w_sum);
      w_nxt_ptr = c_id_width'(w_nxt);
   end

   // Words in the ROM pipeline plus words buffered must never exceed FIFO_DEPTH.
   assign w_used  = (c_cnt_w + 1)'(r_count) + (c_cnt_w + 1)'(r_vld[0])
                  + (c_cnt_w + 1)'(r_vld[1]);
   assign w_issue = (r_state == ST_STREAM) && (w_used < (c_cnt_w + 1)'(FIFO_DEPTH));
   assign w_push  = r_vld[1];
   assign w_pop   = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_grant     <= '0;
         r_cnt       <= '0;
         r_addr_hold <= '0;
         r_vld       <= '0;
         r_lst       <= '0;
         r_rr_ptr    <= '0;
         r_id        <= '0;
      end else begin
         r_grant <= '0;
         r_vld   <= {r_vld[0], w_issue};
         r_lst   <= {r_lst[0], w_issue && (r_cnt == c_last_addr)};
         if (w_issue) begin
            r_addr_hold <= r_cnt;
            r_cnt       <= r_cnt + ADDR_WIDTH'(1);
         end
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_grant  <= NUM_REQ'(1) << w_win;
                  r_id     <= w_win;
                  r_rr_ptr <= w_nxt_ptr;
                  r_cnt    <= '0;
                  r_state  <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (w_issue && (r_cnt == c_last_addr)) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if ((r_vld == 2'b00) && (r_count == '0)) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + c_ptr_w'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {r_lst[1], rom_q};
      end
   end

   assign w_head    = r_mem[r_rd_ptr];
   assign out_valid = (r_count != '0);
   assign out_data  = w_head[DATA_WIDTH-1:0];
   assign out_last  = out_valid && w_head[DATA_WIDTH];
   assign out_id    = r_id;
   assign req_grant = r_grant;
   assign rom_addr  = w_issue ? r_cnt : r_addr_hold;
   assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_weight_rom_stream_arbiter.sv
// ============================================================================
//  Module      : tb_weight_rom_stream_arbiter
//  Description : Scoreboard bench for weight_rom_stream_arbiter with a
//                2-cycle ROM model and a round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weight_rom_stream_arbiter;

   localparam int NUM_REQ    = 3;
   localparam int DATA_WIDTH = 32;
   localparam int DEPTH      = 8;
   localparam int ADDR_WIDTH = 4;
   localparam int FIFO_DEPTH = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_grant;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_q = '0;
   logic [DATA_WIDTH-1:0] rom_s1 = '0;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;
   logic [1:0]            out_id;
   logic                  busy;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic [1:0]  id;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_hs  = 0;
   int   model_ptr = 0;
   logic [NUM_REQ-1:0] prev_req = '0;

   weight_rom_stream_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_grant(req_grant),
      .rom_addr (rom_addr),
      .rom_q    (rom_q),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last (out_last),
      .out_id   (out_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input int a);
      return 32'hBEEF_0000 | 32'(a * 37 + 5);
   endfunction

   // Synchronous ROM with two cycles of read latency.
   always @(posedge clk) begin
      rom_s1 <= rom_word(int'(rom_addr));
      rom_q  <= rom_s1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: reference arbitration, scoreboard fill and output comparison.
   initial begin : monitor
      int   win;
      int   j;
      logic hold_v;
      logic [34:0] hold_w;
      exp_t e;
      hold_v = 1'b0;
      hold_w = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_v = 1'b0;
         end else begin
            if (req_grant !== '0) begin
               win = -1;
               for (int i = 0; i < NUM_REQ; i++) begin
                  j = (model_ptr + i) % NUM_REQ;
                  if (win < 0 && prev_req[j]) win = j;
               end
               chk("grant_while_pass_open", exp_q.size(), 0);
               if (win < 0) begin
                  chk("grant_without_request", req_grant, 0);
               end else begin
                  chk("grant_winner", req_grant, 3'b001 << win);
                  for (int a = 0; a < DEPTH; a++) begin
                     e.data = rom_word(a);
                     e.last = (a == DEPTH - 1);
                     e.id   = 2'(win);
                     exp_q.push_back(e);
                  end
                  model_ptr = (win + 1) % NUM_REQ;
               end
            end
            if (hold_v) begin
               chk("stall_valid_kept", out_valid, 1);
               if (out_valid) chk("stall_stable", {out_data, out_last, out_id}, hold_w);
            end
            hold_v = out_valid && !out_ready;
            hold_w = {out_data, out_last, out_id};
            if (out_valid && out_ready) begin
               n_hs++;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_word: got %0h/%0b/%0d expected none",
                           out_data, out_last, out_id);
               end else begin
                  e = exp_q.pop_front();
                  chk("word", {out_data, out_last, out_id}, {e.data, e.last, e.id});
               end
            end
         end
         prev_req = req_valid;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      exp_q.delete();
      model_ptr = 0;
      rst = 1'b0;
   endtask

   task automatic wait_grant(input int budget, output logic [NUM_REQ-1:0] g);
      g = '0;
      for (int c = 0; c < budget && g == '0; c++) begin
         tick();
         if (req_grant != '0) begin
            g = req_grant;
            req_valid = req_valid & ~req_grant;
         end
      end
      chk("grant_seen", (g != '0), 1);
   endtask

   task automatic wait_idle(input int budget, input logic rnd);
      logic done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         tick();
         if (rnd) out_ready = 1'($urandom % 2);
         if (!busy && exp_q.size() == 0 && req_grant == '0) done = 1'b1;
      end
      chk("idle_reached", done, 1);
      out_ready = 1'b1;
   endtask

   initial begin : driver
      logic [NUM_REQ-1:0] g;
      int ord[4];
      int ng;
      int base;
      logic ok;
      ord = '{0, 1, 2, 0};
      rst = 1'b1;
      req_valid = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_grant", req_grant, 0);
      chk("rst_addr", rom_addr, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_id", out_id, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      model_ptr = 0;

      // Single requester 1, free-flowing output.
      req_valid = 3'b010;
      out_ready = 1'b1;
      wait_grant(20, g);
      chk("single_grant", g, 3'b010);
      chk("single_busy", busy, 1);
      chk("single_id", out_id, 1);
      for (int i = 0; i < DEPTH; i++) begin
         chk("single_addr", rom_addr, i);
         tick();
      end
      wait_idle(60, 1'b0);
      chk("single_busy_low", busy, 0);

      // All three requesting continuously: order 0,1,2,0.
      do_reset();
      req_valid = 3'b111;
      ng = 0;
      for (int c = 0; c < 300 && ng < 4; c++) begin
         tick();
         req_valid = 3'b111;
         if (req_grant != '0) begin
            chk("rr_order", req_grant, 3'b001 << ord[ng]);
            req_valid = 3'b111 & ~req_grant;
            ng++;
         end
      end
      req_valid = '0;
      chk("rr_grants", ng, 4);
      wait_idle(80, 1'b0);

      // Random requests and random backpressure.
      ng = 0;
      for (int c = 0; c < 1500 && ng < 6; c++) begin
         tick();
         out_ready = 1'($urandom % 2);
         if ($urandom % 4 == 0) req_valid = req_valid | 3'(1 << ($urandom % 3));
         if (req_grant != '0) begin
            req_valid = req_valid & ~req_grant;
            ng++;
         end
      end
      req_valid = '0;
      chk("random_grants", ng, 6);
      wait_idle(200, 1'b1);

      // Output blocked from the start: exactly four issues.
      do_reset();
      req_valid = 3'b001;
      out_ready = 1'b0;
      wait_grant(20, g);
      for (int i = 0; i < 20; i++) begin
         chk("stall_addr", rom_addr, (i < 4) ? i : 3);
         tick();
      end
      chk("stall_out_valid", out_valid, 1);
      chk("stall_head", out_data, rom_word(0));
      out_ready = 1'b1;
      wait_idle(80, 1'b0);

      // Reset in the middle of a pass.
      req_valid = 3'b010;
      wait_grant(20, g);
      base = n_hs;
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         if (n_hs >= base + 3) ok = 1'b1;
         else tick();
      end
      chk("three_words", ok, 1);
      rst = 1'b1;
      tick();
      chk("mid_rst_grant", req_grant, 0);
      chk("mid_rst_addr", rom_addr, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_last", out_last, 0);
      chk("mid_rst_id", out_id, 0);
      chk("mid_rst_busy", busy, 0);
      exp_q.delete();
      model_ptr = 0;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("no_stale_valid", out_valid, 0);
      end
      req_valid = 3'b011;
      wait_grant(20, g);
      chk("restart_grant", g, 3'b001);
      chk("restart_addr", rom_addr, 0);
      wait_grant(80, g);
      chk("restart_next_grant", g, 3'b010);
      req_valid = '0;
      wait_idle(80, 1'b0);

      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
